// File: rtl/ad_pkg.sv
// Shared types for the ad playback path:
// ad codes, player states and the number of ads.
package ad_pkg;

  typedef enum logic [1:0] {
    AD_DIE_HARD       = 2'd0,
    AD_SAFE_HAVEN     = 2'd1,
    AD_ESCAPE_EARTH   = 2'd2,
    AD_SAVING_LINCOLN = 2'd3
  } ad_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_ADS = 4;

endpackage

// File: rtl/ad_player_sat_counter.sv
// Saturating up-counter, one per ad impression.
// Ports: clk, reset (sync, high), inc, q[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ad_player.sv
// Ad player: accepts an ad code over valid/ready,
// plays it AD_CYCLES cycles, pulses done, and keeps
// saturating per-ad impression counters.
// Ports: clk, reset (sync, high); req_valid/req_ready/
// req_m request; skip; playing, cur_m, done, skipped
// status; imp_sel -> imp_cnt counter read.
// Build option: define AD_SKIP_EN to honour skip.
module ad_player
  import ad_pkg::*;
#(
  parameter int AD_CYCLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_m,
  input  logic             skip,
  output logic             playing,
  output logic [1:0]       cur_m,
  output logic             done,
  output logic             skipped,
  input  logic [1:0]       imp_sel,
  output logic [CNT_W-1:0] imp_cnt
);

  localparam int TW =
    (AD_CYCLES > 1) ? $clog2(AD_CYCLES) : 1;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  ad_t           r_cur_m;
  logic          r_ready;
  logic          r_playing;
  logic          r_done;
  logic          r_skipped;

  logic w_last;
  logic w_skip;

  assign w_last = (r_state == ST_PLAY) &&
                  (r_timer == '0);

`ifdef AD_SKIP_EN
  // completion on the last cycle beats skip
  assign w_skip = (r_state == ST_PLAY) &&
                  skip && (r_timer != '0);
`else
  logic w_unused_skip;
  assign w_unused_skip = skip;
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_cur_m   <= AD_DIE_HARD;
      r_ready   <= 1'b1;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
      r_skipped <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_skipped <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cur_m   <= ad_t'(req_m);
            r_timer   <= TW'(AD_CYCLES - 1);
            r_state   <= ST_PLAY;
            r_ready   <= 1'b0;
            r_playing <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_last || w_skip) begin
            r_state   <= ST_DONE;
            r_playing <= 1'b0;
            r_done    <= 1'b1;
            r_skipped <= w_skip;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_ready   <= 1'b1;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  logic [CNT_W-1:0] w_cnt [NUM_ADS];

  for (genvar gi = 0; gi < NUM_ADS; gi++) begin : g_cnt
    logic w_inc;
    assign w_inc = w_last &&
                   (r_cur_m == ad_t'(gi));
    sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc),
      .q     (w_cnt[gi])
    );
  end

  assign req_ready = r_ready;
  assign playing   = r_playing;
  assign done      = r_done;
  assign skipped   = r_skipped;
  assign cur_m     = r_cur_m;
  assign imp_cnt   = w_cnt[imp_sel];

endmodule

// File: tb/tb_ad_player.sv
// Bench for ad_player: two instances (8-cycle/2-bit
// counters and 1-cycle/8-bit) against an age model.
module tb_ad_player;

  localparam int AD0 = 8;
  localparam int CW0 = 2;
  localparam int AD1 = 1;
  localparam int CW1 = 8;

`ifdef AD_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       vld [2];
  logic [1:0] rm  [2];
  logic       skp [2];
  logic [1:0] sel [2];
  logic       rdy [2];
  logic       ply [2];
  logic       dn  [2];
  logic       skd [2];
  logic [1:0] cm  [2];
  logic [CW0-1:0] ic0;
  logic [CW1-1:0] ic1;

  ad_player #(.AD_CYCLES(AD0), .CNT_W(CW0)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_m(rm[0]), .skip(skp[0]),
    .playing(ply[0]), .cur_m(cm[0]),
    .done(dn[0]), .skipped(skd[0]),
    .imp_sel(sel[0]), .imp_cnt(ic0)
  );

  ad_player #(.AD_CYCLES(AD1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_m(rm[1]), .skip(skp[1]),
    .playing(ply[1]), .cur_m(cm[1]),
    .done(dn[1]), .skipped(skd[1]),
    .imp_sel(sel[1]), .imp_cnt(ic1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Model: a play is described by its age (cycles
  // since acceptance, 1 = first playing cycle) and
  // its length (AD, or shorter if skipped).
  int act [2];
  int age [2];
  int len [2];
  int cur [2];
  int cnt [2][4];

  function automatic int adl(int k);
    return (k == 0) ? AD0 : AD1;
  endfunction

  function automatic int cmax(int k);
    return (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
  endfunction

  task automatic model_edge(int k);
    int a;
    a = adl(k);
    if (rst[k]) begin
      act[k] = 0; age[k] = 0;
      len[k] = 0; cur[k] = 0;
      for (int i = 0; i < 4; i++) cnt[k][i] = 0;
    end else if (act[k] != 0) begin
      if (SKIP_EN && skp[k] && age[k] <= len[k] &&
          age[k] < a)
        len[k] = age[k];
      if (age[k] == a && len[k] == a &&
          cnt[k][cur[k]] < cmax(k))
        cnt[k][cur[k]]++;
      age[k]++;
      if (age[k] == len[k] + 2) act[k] = 0;
    end else if (vld[k]) begin
      act[k] = 1; age[k] = 1;
      len[k] = a; cur[k] = int'(rm[k]);
    end
  endtask

  task automatic check_outs(int k);
    int e_play, e_done, ic;
    e_play = (act[k] != 0 && age[k] <= len[k]) ? 1 : 0;
    e_done = (act[k] != 0 && age[k] == len[k] + 1) ? 1 : 0;
    ic = (k == 0) ? int'(ic0) : int'(ic1);
    check($sformatf("d%0d_ready", k),
          int'(rdy[k]), (act[k] == 0) ? 1 : 0);
    check($sformatf("d%0d_playing", k),
          int'(ply[k]), e_play);
    check($sformatf("d%0d_done", k),
          int'(dn[k]), e_done);
    check($sformatf("d%0d_skipped", k), int'(skd[k]),
          (e_done == 1 && len[k] < adl(k)) ? 1 : 0);
    check($sformatf("d%0d_cur_m", k),
          int'(cm[k]), cur[k]);
    check($sformatf("d%0d_imp_cnt%0d", k, sel[k]),
          ic, cnt[k][sel[k]]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_edge(k);
    for (int k = 0; k < 2; k++) check_outs(k);
  endtask

  task automatic read_all();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 2; k++) sel[k] = 2'(s);
      #1;
      check("d0_cnt_all", int'(ic0), cnt[0][s]);
      check("d1_cnt_all", int'(ic1), cnt[1][s]);
    end
  endtask

  task automatic drive(bit r, bit v, logic [1:0] m,
                       bit s, logic [1:0] sl);
    for (int k = 0; k < 2; k++) begin
      rst[k] = r; vld[k] = v; rm[k] = m;
      skp[k] = s; sel[k] = sl;
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; age[k] = 0; len[k] = 0; cur[k] = 0;
      for (int i = 0; i < 4; i++) cnt[k][i] = 0;
    end
    drive(1, 0, 2'd0, 0, 2'd0);
    steps(2);
    read_all();

    // single play of ad 10
    drive(0, 1, 2'd2, 0, 2'd2);
    step();
    vld[0] = 0; vld[1] = 0;
    steps(12);

    // valid held, code changing during play
    for (int i = 0; i < 30; i++) begin
      drive(0, 1, 2'($urandom_range(0, 3)), 0, 2'd3);
      step();
    end
    drive(0, 0, 2'd0, 0, 2'd1);
    steps(12);

    // saturation: repeated plays of ad 01
    drive(1, 0, 2'd0, 0, 2'd1);
    step();
    drive(0, 1, 2'd1, 0, 2'd1);
    steps(55);
    drive(0, 0, 2'd1, 0, 2'd1);
    steps(12);

    // skip on third playing cycle, then on last
    drive(0, 1, 2'd0, 0, 2'd0);
    step();
    drive(0, 0, 2'd0, 0, 2'd0);
    steps(2);
    skp[0] = 1;
    step();
    skp[0] = 0;
    steps(12);
    drive(0, 1, 2'd0, 0, 2'd0);
    step();
    drive(0, 0, 2'd0, 0, 2'd0);
    steps(AD0 - 1);
    skp[0] = 1;
    step();
    skp[0] = 0;
    steps(4);

    // reset in the middle of a play
    drive(0, 1, 2'd3, 0, 2'd3);
    step();
    vld[0] = 0; vld[1] = 0;
    steps(3);
    rst[0] = 1; rst[1] = 1;
    step();
    rst[0] = 0; rst[1] = 0;
    read_all();
    steps(3);

    // back-to-back 00 then 11
    drive(0, 1, 2'd0, 0, 2'd0);
    step();
    rm[0] = 2'd3; rm[1] = 2'd3;
    steps(6);
    vld[0] = 0; vld[1] = 0;
    steps(12);
    read_all();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k] = ($urandom_range(0, 99) == 0);
        vld[k] = ($urandom_range(0, 1) == 1);
        rm[k]  = 2'($urandom_range(0, 3));
        skp[k] = ($urandom_range(0, 3) == 0);
        sel[k] = 2'($urandom_range(0, 3));
      end
      step();
    end
    read_all();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
